// File: rtl/lane_deserializer_if.sv
// Lane deserializer bus: serial lane inputs from the sink stage and the buffered word-set output.
// The slave modport is the deserializer; the master modport is whatever drives and consumes it.
interface lane_deserializer_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
) ();
  logic [N-1:0]         lane_bits;
  logic                 lane_strobe;
  logic [N*W-1:0]       out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 overflow;
  logic                 clr_ovf;
  logic [$clog2(W)-1:0] bit_cnt;

  modport slave (
    input  lane_bits,
    input  lane_strobe,
    input  out_ready,
    input  clr_ovf,
    output out_data,
    output out_valid,
    output overflow,
    output bit_cnt
  );

  modport master (
    output lane_bits,
    output lane_strobe,
    output out_ready,
    output clr_ovf,
    input  out_data,
    input  out_valid,
    input  overflow,
    input  bit_cnt
  );
endinterface

// File: rtl/lane_deserializer.sv
// Collects W MSB-first bits on each of N lanes into a word set and queues completed sets
// in a 2-entry buffer; a set arriving while the buffer is full and not popping is dropped.
module lane_deserializer #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lane_deserializer_if.slave    bus_io
);

  localparam int unsigned CntW = $clog2(W);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  logic [N-1:0][W-1:0] shift_q, shift_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [N*W-1:0]      word_d;
  logic                push, pop, drop;

  state_e              state_q;
  logic [N*W-1:0]      head_q, tail_q;
  logic                valid_q, ovf_q;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    if (bus_io.lane_strobe) begin
      for (int i = 0; i < N; i++) begin
        shift_d[i] = {shift_q[i][W-2:0], bus_io.lane_bits[i]};
      end
      if (cnt_q == CntW'(W - 1)) begin
        cnt_d = '0;
        push  = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // The completing strobe's own bit is part of the pushed set, so push from shift_d.
  assign word_d = shift_d;
  assign pop    = valid_q & bus_io.out_ready;
  assign drop   = (state_q == StFull) & push & ~pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (push) begin
            head_q  <= word_d;
            valid_q <= 1'b1;
            state_q <= StOne;
          end
        end
        StOne: begin
          if (push && pop) begin
            head_q <= word_d;
          end else if (push) begin
            tail_q  <= word_d;
            state_q <= StFull;
          end else if (pop) begin
            valid_q <= 1'b0;
            state_q <= StEmpty;
          end
        end
        StFull: begin
          if (pop) begin
            head_q <= tail_q;
            if (push) begin
              tail_q <= word_d;
            end else begin
              state_q <= StOne;
            end
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= StEmpty;
        end
      endcase

      // A fresh drop outranks a clear in the same cycle.
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (bus_io.clr_ovf) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign bus_io.out_data  = head_q;
  assign bus_io.out_valid = valid_q;
  assign bus_io.overflow  = ovf_q;
  assign bus_io.bit_cnt   = cnt_q;

endmodule

// File: tb/tb_lane_deserializer.sv
// Bench for lane_deserializer: directed table, corner-case sequences and a randomized run
// checked every cycle against a queue-based reference model.
module tb_lane_deserializer;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned DW = N * W;

  logic clk;
  logic rst_n;

  lane_deserializer_if #(.N(N), .W(W)) bus ();

  lane_deserializer #(.N(N), .W(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: per-lane bit lists and a bounded queue of finished word sets.
  bit             mlane[N][$];
  logic [DW-1:0]  mq[$];
  bit             movf;
  int             words_done;

  typedef struct {
    logic          strobe;
    logic [N-1:0]  bits;
    logic          ready;
    logic          clr;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    logic          exp_ovf;
    logic [2:0]    exp_cnt;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) mlane[i].delete();
    mq.delete();
    movf = 1'b0;
  endtask

  task automatic model_edge();
    bit            pop;
    bit            complete;
    bit            drop;
    logic [DW-1:0] w;
    pop      = (mq.size() != 0) && (bus.out_ready === 1'b1);
    complete = 1'b0;
    drop     = 1'b0;
    w        = '0;
    if (bus.lane_strobe === 1'b1) begin
      for (int i = 0; i < N; i++) mlane[i].push_back(bus.lane_bits[i]);
      if (mlane[0].size() == W) begin
        complete = 1'b1;
        for (int i = 0; i < N; i++) begin
          for (int k = 0; k < W; k++) w[i*W + W-1-k] = mlane[i][k];
          mlane[i].delete();
        end
      end
    end
    if (pop) void'(mq.pop_front());
    if (complete) begin
      words_done++;
      if (mq.size() == 2) drop = 1'b1;
      else mq.push_back(w);
    end
    if (drop) movf = 1'b1;
    else if (bus.clr_ovf === 1'b1) movf = 1'b0;
  endtask

  task automatic compare_model();
    chk("valid", 64'(bus.out_valid), 64'(mq.size() != 0));
    chk("overflow", 64'(bus.overflow), 64'(movf));
    chk("bit_cnt", 64'(bus.bit_cnt), 64'(mlane[0].size()));
    if (mq.size() != 0) chk("data", 64'(bus.out_data), 64'(mq[0]));
  endtask

  task automatic drive(input logic strobe, input logic [N-1:0] bits, input logic ready,
                       input logic clr);
    bus.lane_strobe = strobe;
    bus.lane_bits   = bits;
    bus.out_ready   = ready;
    bus.clr_ovf     = clr;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  // Eight strobes carrying ws; out_ready is rdy except on the completing strobe.
  task automatic send_word(input logic [DW-1:0] ws, input logic rdy, input logic rdy_last);
    logic [N-1:0] b;
    for (int j = 0; j < W; j++) begin
      for (int i = 0; i < N; i++) b[i] = ws[i*W + W-1-j];
      drive(1'b1, b, (j == W - 1) ? rdy_last : rdy, 1'b0);
      cycle();
    end
  endtask

  initial begin
    logic [DW-1:0] wa, wb, wc;
    int            target;
    int            cyc;
    int            thr;

    words_done = 0;
    drive(1'b0, '0, 1'b0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #12;
    chk("reset_valid", 64'(bus.out_valid), 64'(0));
    chk("reset_data", 64'(bus.out_data), 64'(0));
    chk("reset_ovf", 64'(bus.overflow), 64'(0));
    chk("reset_cnt", 64'(bus.bit_cnt), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Alternating 0001/0000 on lane 0 builds 8'hAA; popped the cycle after it appears.
    for (int j = 0; j < 8; j++) begin
      tbl[j].strobe    = 1'b1;
      tbl[j].bits      = (j % 2 == 0) ? 4'b0001 : 4'b0000;
      tbl[j].ready     = 1'b1;
      tbl[j].clr       = 1'b0;
      tbl[j].exp_valid = (j == 7);
      tbl[j].exp_data  = 32'h0000_00AA;
      tbl[j].exp_ovf   = 1'b0;
      tbl[j].exp_cnt   = 3'((j + 1) % 8);
    end
    for (int j = 8; j < 10; j++) begin
      tbl[j].strobe    = 1'b0;
      tbl[j].bits      = 4'b0000;
      tbl[j].ready     = 1'b1;
      tbl[j].clr       = 1'b0;
      tbl[j].exp_valid = 1'b0;
      tbl[j].exp_data  = '0;
      tbl[j].exp_ovf   = 1'b0;
      tbl[j].exp_cnt   = 3'd0;
    end
    for (int j = 0; j < 10; j++) begin
      drive(tbl[j].strobe, tbl[j].bits, tbl[j].ready, tbl[j].clr);
      cycle();
      chk("tbl_valid", 64'(bus.out_valid), 64'(tbl[j].exp_valid));
      chk("tbl_ovf", 64'(bus.overflow), 64'(tbl[j].exp_ovf));
      chk("tbl_cnt", 64'(bus.bit_cnt), 64'(tbl[j].exp_cnt));
      if (tbl[j].exp_valid) chk("tbl_data", 64'(bus.out_data), 64'(tbl[j].exp_data));
    end

    // Three sets with no consumer: first two held in order, third dropped.
    wa = 32'h1122_3344;
    wb = 32'hA5C3_0F96;
    wc = 32'h7E81_DB24;
    send_word(wa, 1'b0, 1'b0);
    send_word(wb, 1'b0, 1'b0);
    send_word(wc, 1'b0, 1'b0);
    chk("hold_head", 64'(bus.out_data), 64'(wa));
    chk("drop_ovf", 64'(bus.overflow), 64'(1));
    drive(1'b0, '0, 1'b1, 1'b0);
    cycle();
    chk("hold_second", 64'(bus.out_data), 64'(wb));
    chk("ovf_sticky", 64'(bus.overflow), 64'(1));
    drive(1'b0, '0, 1'b0, 1'b1);
    cycle();
    chk("ovf_clear", 64'(bus.overflow), 64'(0));
    drive(1'b0, '0, 1'b1, 1'b0);
    cycle();
    chk("drained", 64'(bus.out_valid), 64'(0));

    // Full buffer, completing strobe coincides with a pop.
    send_word(wa, 1'b0, 1'b0);
    send_word(wb, 1'b0, 1'b0);
    send_word(wc, 1'b0, 1'b1);
    chk("pushpop_ovf", 64'(bus.overflow), 64'(0));
    chk("pushpop_head", 64'(bus.out_data), 64'(wb));
    drive(1'b0, '0, 1'b1, 1'b0);
    cycle();
    chk("pushpop_second", 64'(bus.out_data), 64'(wc));
    chk("pushpop_valid", 64'(bus.out_valid), 64'(1));
    drive(1'b0, '0, 1'b1, 1'b0);
    cycle();

    // Partial word, then reset mid-word; the next word must carry no residue.
    for (int j = 0; j < 5; j++) begin
      drive(1'b1, 4'b1010, 1'b1, 1'b0);
      cycle();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midreset_cnt", 64'(bus.bit_cnt), 64'(0));
    chk("midreset_data", 64'(bus.out_data), 64'(0));
    chk("midreset_valid", 64'(bus.out_valid), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("postreset_cnt", 64'(bus.bit_cnt), 64'(0));
    send_word(32'hFFFF_FFFF, 1'b1, 1'b1);
    chk("ff_valid", 64'(bus.out_valid), 64'(1));
    chk("ff_data", 64'(bus.out_data), 64'(32'hFFFF_FFFF));
    drive(1'b0, '0, 1'b1, 1'b0);
    cycle();
    chk("ff_popped", 64'(bus.out_valid), 64'(0));

    // Random gaps and stall bursts alternate with freely-draining phases.
    target = words_done + 1000;
    cyc    = 0;
    thr    = 60;
    while (words_done < target && cyc < 60000) begin
      if (cyc % 200 == 0) thr = (thr == 60) ? 3 : 60;
      drive(1'b1 && ($urandom_range(0, 3) != 0), N'($urandom), $urandom_range(0, 99) < thr,
            $urandom_range(0, 15) == 0);
      cycle();
      cyc++;
    end
    chk("random_word_budget", 64'(words_done >= target), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
